// File: rtl/rect_perm_pipe_if.sv
// Handshake bundle for rect_perm_pipe: input word channel, output word channel
// and the occupancy flag. The producer/consumer side uses the master modport,
// the permutation pipeline uses the slave modport.
interface rect_perm_pipe_if #(
  parameter int unsigned W     = 64,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_inv;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_data, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  in_valid, in_data, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/rect_perm_pipe.sv
// RECTANGLE ShiftRow layer as an elastic pipeline. Row 0 passes through,
// rows 1..3 rotate left (forward) or right (inverse) by ROT1..ROT3 mod ROW_W.
// The permutation is applied before stage 1; later stages only delay the word.
module rect_perm_pipe #(
  parameter int unsigned ROW_W  = 16,
  parameter int unsigned ROT1   = 1,
  parameter int unsigned ROT2   = 12,
  parameter int unsigned ROT3   = 13,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input logic             clk,
  input logic             rst,
  rect_perm_pipe_if.slave bus
);

  localparam int unsigned W = 4 * ROW_W;
  // Row 0 uses amount 0, which makes both rotate helpers return it unchanged.
  localparam int unsigned ROT_AMT [4] = '{0, ROT1 % ROW_W, ROT2 % ROW_W, ROT3 % ROW_W};

  logic [W-1:0]      r_data [STAGES];
  logic [TAG_W-1:0]  r_tag  [STAGES];
  logic [STAGES-1:0] r_v;
  logic              r_busy;

  logic [STAGES-1:0] w_ld;
  logic [STAGES-1:0] w_v_nxt;
  logic [W-1:0]      w_perm;

  function automatic logic [ROW_W-1:0] rotl(input logic [ROW_W-1:0] x,
                                            input int unsigned      amt);
    logic [2*ROW_W-1:0] w_dbl;
    w_dbl = {x, x} << amt;
    return w_dbl[2*ROW_W-1 -: ROW_W];
  endfunction

  function automatic logic [ROW_W-1:0] rotr(input logic [ROW_W-1:0] x,
                                            input int unsigned      amt);
    logic [2*ROW_W-1:0] w_dbl;
    w_dbl = {x, x} >> amt;
    return w_dbl[ROW_W-1:0];
  endfunction

  // Row-wise rotation of the incoming word, direction chosen per word by in_inv.
  always_comb begin
    w_perm = bus.in_data;
    for (int unsigned r = 0; r < 4; r++) begin
      if (bus.in_inv)
        w_perm[r*ROW_W +: ROW_W] = rotr(bus.in_data[r*ROW_W +: ROW_W], ROT_AMT[r]);
      else
        w_perm[r*ROW_W +: ROW_W] = rotl(bus.in_data[r*ROW_W +: ROW_W], ROT_AMT[r]);
    end
  end

  // Load enables ripple from the output back to the input: a stage loads when
  // it is empty or when the stage after it (or the consumer) takes its word.
  always_comb begin
    logic w_take;
    w_ld   = '0;
    w_take = bus.out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_ld[STAGES-1-i] = !r_v[STAGES-1-i] || w_take;
      w_take           = w_ld[STAGES-1-i];
    end
  end

  // Next occupancy of each stage; empty stages pull from upstream even under stall.
  always_comb begin
    w_v_nxt = r_v;
    if (w_ld[0])
      w_v_nxt[0] = bus.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (w_ld[k])
        w_v_nxt[k] = r_v[k-1];
    end
  end

  // Valid bits and the registered busy flag (derived from next occupancy so
  // busy itself has no combinational path from the ports).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v    <= '0;
      r_busy <= 1'b0;
    end else begin
      r_v    <= w_v_nxt;
      r_busy <= |w_v_nxt;
    end
  end

  // Payload registers: only move when a real word is transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      if (w_ld[0] && bus.in_valid) begin
        r_data[0] <= w_perm;
        r_tag[0]  <= bus.in_tag;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (w_ld[k] && r_v[k-1]) begin
          r_data[k] <= r_data[k-1];
          r_tag[k]  <= r_tag[k-1];
        end
      end
    end
  end

  assign bus.in_ready  = w_ld[0];
  assign bus.out_valid = r_v[STAGES-1];
  assign bus.out_data  = r_data[STAGES-1];
  assign bus.out_tag   = r_tag[STAGES-1];
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_rect_perm_pipe.sv
// Bench for rect_perm_pipe: bit-level reference permutation, scoreboard with
// occupancy tracking on the default instance, plus STAGES=1 and ROW_W=8/STAGES=4
// instances for latency and round-trip behaviour.
module tb_rect_perm_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rect_perm_pipe_if #(.W(64), .TAG_W(4)) bus  ();
  rect_perm_pipe_if #(.W(64), .TAG_W(4)) bus1 ();
  rect_perm_pipe_if #(.W(32), .TAG_W(4)) bus8 ();

  rect_perm_pipe #(.ROW_W(16), .ROT1(1), .ROT2(12), .ROT3(13), .STAGES(2), .TAG_W(4))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  rect_perm_pipe #(.ROW_W(16), .ROT1(1), .ROT2(12), .ROT3(13), .STAGES(1), .TAG_W(4))
    u_s1 (.clk(clk), .rst(rst), .bus(bus1));
  rect_perm_pipe #(.ROW_W(8), .ROT1(0), .ROT2(12), .ROT3(13), .STAGES(4), .TAG_W(4))
    u_s8 (.clk(clk), .rst(rst), .bus(bus8));

  int checks   = 0;
  int failures = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // Reference: move every bit of each row to its rotated position.
  function automatic logic [63:0] model_perm(logic [63:0] x, logic inv, int unsigned rw,
                                             int unsigned r1, int unsigned r2, int unsigned r3);
    logic [63:0] y;
    int unsigned rots [4];
    int unsigned amt, dst;
    y = '0;
    rots = '{0, r1, r2, r3};
    for (int unsigned r = 0; r < 4; r++) begin
      amt = rots[r] % rw;
      for (int unsigned i = 0; i < rw; i++) begin
        dst = inv ? (i + rw - amt) % rw : (i + amt) % rw;
        y[r*rw + dst] = x[r*rw + i];
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] m16(logic [63:0] x, logic inv);
    return model_perm(x, inv, 16, 1, 12, 13);
  endfunction

  function automatic logic [63:0] m8(logic [63:0] x, logic inv);
    return model_perm(x, inv, 8, 0, 12, 13);
  endfunction

  // ---------------- scoreboard / compare process (default instance) ----------
  typedef struct {
    logic [63:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  int          occ        = 0;
  int          run        = 0;
  int          max_run    = 0;
  int          acc_cnt    = 0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [3:0]  prev_tag;

  always @(negedge clk) begin
    check("busy", bus.busy, occ != 0);
    check("in_ready", bus.in_ready, (occ < 2) || bus.out_ready);
    if (prev_stall) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, prev_data);
      check("hold_tag", bus.out_tag, prev_tag);
    end
    if (rst) begin
      exp_q.delete();
      occ        = 0;
      run        = 0;
      prev_stall = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=%h expected=none", bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", bus.out_data, mon_e.d);
          check("out_tag", bus.out_tag, mon_e.t);
          occ--;
        end
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{m16(bus.in_data, bus.in_inv), bus.in_tag});
        occ++;
        acc_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_tag   = bus.out_tag;
    end
  end

  // ---------------- drivers --------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(string name, logic [63:0] d, logic inv, logic [3:0] t,
                       logic [63:0] exp_d, logic [3:0] exp_t4);
    int lat;
    cyc();
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_inv    = inv;
    bus.in_tag    = t;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({name, "_acc"}, bus.in_ready, 1);
    cyc();
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check({name, "_lat"}, lat, 2);
    check({name, "_data"}, bus.out_data, exp_d);
    check({name, "_tag"}, bus.out_tag, exp_t4);
  endtask

  task automatic s1_send(logic [63:0] d, logic inv, logic [3:0] t);
    int lat;
    cyc();
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    bus1.in_inv   = inv;
    bus1.in_tag   = t;
    @(negedge clk);
    check("s1_acc", bus1.in_ready, 1);
    cyc();
    bus1.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus1.out_valid) break;
    end
    check("s1_lat", lat, 1);
    check("s1_data", bus1.out_data, m16(d, inv));
    check("s1_tag", bus1.out_tag, t);
  endtask

  task automatic s8_xfer(logic [31:0] d, logic inv, logic [3:0] t,
                         output logic [31:0] y);
    int lat;
    cyc();
    bus8.in_valid = 1'b1;
    bus8.in_data  = d;
    bus8.in_inv   = inv;
    bus8.in_tag   = t;
    @(negedge clk);
    check("s8_acc", bus8.in_ready, 1);
    cyc();
    bus8.in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus8.out_valid) break;
    end
    check("s8_lat", lat, 4);
    check("s8_tag", bus8.out_tag, t);
    y = bus8.out_data;
  endtask

  logic [63:0] stream_d [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                                64'hA5A5_A5A5_5A5A_5A5A, 64'h0123_4567_89AB_CDEF,
                                64'h1234_5678_9ABC_DEF0};

  initial begin
    logic [31:0] x8, y8, z8;
    bus.in_valid  = 1'b0; bus.in_data  = '0; bus.in_inv  = 1'b0; bus.in_tag  = '0; bus.out_ready  = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_inv = 1'b0; bus1.in_tag = '0; bus1.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_inv = 1'b0; bus8.in_tag = '0; bus8.out_ready = 1'b1;

    // Reset values
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Hand-computed values pinning the reference model
    check("model_fwd", m16(64'h1234_5678_9ABC_DEF0, 1'b0), 64'h8246_8567_3579_DEF0);
    check("model_inv", m16(64'h8246_8567_3579_DEF0, 1'b1), 64'h1234_5678_9ABC_DEF0);
    check("model_a5", m16(64'hA5A5_A5A5_5A5A_5A5A, 1'b0), 64'hB4B4_5A5A_B4B4_5A5A);
    check("model_ones", m16(64'hFFFF_FFFF_FFFF_FFFF, 1'b1), 64'hFFFF_FFFF_FFFF_FFFF);
    check("model_row8", m8(64'h0000_0000_0101_0101, 1'b0), 64'h0000_0000_2010_0101);

    // Directed single words
    send1("fwd", 64'h1234_5678_9ABC_DEF0, 1'b0, 4'd3, 64'h8246_8567_3579_DEF0, 4'd3);
    send1("inv", 64'h8246_8567_3579_DEF0, 1'b1, 4'd9, 64'h1234_5678_9ABC_DEF0, 4'd9);
    send1("a5",  64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 4'd1, 64'hB4B4_5A5A_B4B4_5A5A, 4'd1);

    // Streaming, alternating modes
    bus.out_ready = 1'b1;
    max_run = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      cyc();
      bus.in_valid = 1'b1;
      bus.in_data  = stream_d[i];
      bus.in_inv   = i[0];
      bus.in_tag   = i[3:0];
    end
    cyc();
    bus.in_valid = 1'b0;
    repeat (4) cyc();
    check("stream_run", max_run, 5);

    // Backpressure: fill with out_ready low, then release
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      cyc();
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom};
      bus.in_inv   = 1'($urandom);
      bus.in_tag   = 4'($urandom);
    end
    @(negedge clk);
    check("bp_accepted", acc_cnt, 2);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    for (int unsigned i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) max_run = 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = {$urandom, $urandom};
      bus.in_inv    = 1'($urandom);
      bus.in_tag    = 4'($urandom);
    end
    cyc();
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    check("bp_run", max_run, 8);
    check("bp_drained", exp_q.size(), 0);

    // Reset mid-stream with two words in flight
    bus.out_ready = 1'b0;
    cyc(); bus.in_valid = 1'b1; bus.in_data = 64'h1111_2222_3333_4444; bus.in_tag = 4'd5;
    cyc(); bus.in_valid = 1'b1; bus.in_data = 64'h5555_6666_7777_8888; bus.in_tag = 4'd6;
    cyc(); rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cyc(); rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_busy", bus.busy, 0);
    send1("post_rst", 64'h1234_5678_9ABC_DEF0, 1'b0, 4'd7, 64'h8246_8567_3579_DEF0, 4'd7);
    repeat (5) cyc();

    // Randomized traffic with occasional resets
    for (int unsigned c = 0; c < 3000; c++) begin
      cyc();
      rst           = ($urandom_range(0, 299) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = {$urandom, $urandom};
      bus.in_inv    = 1'($urandom);
      bus.in_tag    = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    cyc();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) cyc();
    check("rand_drained", exp_q.size(), 0);

    // STAGES=1 instance
    for (int unsigned i = 0; i < 20; i++)
      s1_send({$urandom, $urandom}, 1'($urandom), 4'($urandom));

    // ROW_W=8, ROT1=0, STAGES=4 instance: round trip and row-1 passthrough
    for (int unsigned i = 0; i < 1000; i++) begin
      x8 = $urandom;
      s8_xfer(x8, 1'b0, 4'(i), y8);
      check("s8_fwd", y8, m8({32'd0, x8}, 1'b0));
      check("s8_row1", y8[15:8], x8[15:8]);
      s8_xfer(y8, 1'b1, 4'(i + 1), z8);
      check("s8_roundtrip", z8, x8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit reached");
  end

endmodule
